// File: rtl/wvb_rdout_arbiter_pkg.sv
// Shared types for the waveform readout arbiter: FSM state encoding and channel-index width.
package wvb_rdout_arbiter_pkg;

    localparam int CHAN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/wvb_rdout_arbiter_if.sv
// Reader-side bus of the readout arbiter: muxed header/data toward WVB_READER, pop strobes back.
interface wvb_rdout_arbiter_if
    import wvb_rdout_arbiter_pkg::*;
#(
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_DATA_WIDTH = 22
);
    // Handshake: rdr_hdr_empty low means a header is presented on rdr_hdr_data; a one-cycle
    // rdr_hdr_rdreq/rdr_wvb_rdreq pops the current word in that same cycle, and rdr_rddone
    // ends the readout. Strobes are ignored unless the arbiter holds a grant.
    logic                    rdr_hdr_empty;
    logic [P_HDR_WIDTH-1:0]  rdr_hdr_data;
    logic [P_DATA_WIDTH-1:0] rdr_wvb_data;
    logic [CHAN_W-1:0]       rdr_chan;
    logic                    rdr_hdr_rdreq;
    logic                    rdr_wvb_rdreq;
    logic                    rdr_rddone;

    modport master (
        output rdr_hdr_empty, rdr_hdr_data, rdr_wvb_data, rdr_chan,
        input  rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_rddone
    );

    modport slave (
        input  rdr_hdr_empty, rdr_hdr_data, rdr_wvb_data, rdr_chan,
        output rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_rddone
    );

endinterface

// File: rtl/wvb_rdout_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_ptr, wrapping modulo N_CHAN.
module rr_arbiter #(
    parameter int N_CHAN = 4,
    parameter int IDX_W  = 4
) (
    input  logic [N_CHAN-1:0] req,
    input  logic [IDX_W-1:0]  last_ptr,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    int cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        // Offset 1..N_CHAN so last_ptr itself is considered last.
        for (int i = 1; i <= N_CHAN; i++) begin
            cand = (int'(last_ptr) + i) % N_CHAN;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/wvb_rdout_arbiter.sv
// Shares one wvb_reader between N_CHAN acquisition channels with round-robin grants,
// same-cycle strobe routing to the granted channel, and an idle watchdog.
module wvb_rdout_arbiter
    import wvb_rdout_arbiter_pkg::*;
#(
    parameter int N_CHAN       = 4,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_TIMEOUT    = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [N_CHAN-1:0]              chan_en,
    input  logic [N_CHAN-1:0]              ch_hdr_empty,
    input  logic [N_CHAN*P_HDR_WIDTH-1:0]  ch_hdr_data,
    input  logic [N_CHAN*P_DATA_WIDTH-1:0] ch_wvb_data,
    output logic [N_CHAN-1:0]              ch_hdr_rdreq,
    output logic [N_CHAN-1:0]              ch_wvb_rdreq,
    output logic [N_CHAN-1:0]              ch_wvb_rddone,
    wvb_rdout_arbiter_if.master            rdr,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [31:0]                    grant_cnt,
    output state_t                         dbg_state
);

    state_t                  state, state_nxt;
    logic [CHAN_W-1:0]       sel;
    logic [CHAN_W-1:0]       last_ptr;
    logic [31:0]             wd_cnt;
    logic [N_CHAN-1:0]       req;
    logic                    pick_valid;
    logic [CHAN_W-1:0]       pick_idx;
    logic                    any_strobe;
    logic                    wd_expire;
    logic                    rd_done;
    logic                    wd_release;
    logic                    hdr_empty_sel;
    logic [P_HDR_WIDTH-1:0]  hdr_data_sel;
    logic [P_DATA_WIDTH-1:0] wvb_data_sel;

    assign req        = en ? (~ch_hdr_empty & chan_en) : '0;
    assign busy       = (state == ST_GRANT);
    assign dbg_state  = state;
    assign any_strobe = rdr.rdr_hdr_rdreq | rdr.rdr_wvb_rdreq | rdr.rdr_rddone;
    assign wd_expire  = (P_TIMEOUT != 0) && !any_strobe && (wd_cnt == 32'(P_TIMEOUT - 1));

    rr_arbiter #(
        .N_CHAN (N_CHAN),
        .IDX_W  (CHAN_W)
    ) u_rr_arbiter (
        .req      (req),
        .last_ptr (last_ptr),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        rd_done    = 1'b0;
        wd_release = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                // en/chan_en are deliberately not looked at here: a started readout always finishes.
                if (rdr.rdr_rddone) begin
                    rd_done   = 1'b1;
                    state_nxt = ST_RELEASE;
                end else if (wd_expire) begin
                    wd_release = 1'b1;
                    state_nxt  = ST_RELEASE;
                end
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel         <= '0;
            last_ptr    <= CHAN_W'(N_CHAN - 1);
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            grant_cnt   <= '0;
        end else begin
            if (state == ST_IDLE && pick_valid) sel <= pick_idx;
            if (rd_done || wd_release)          last_ptr <= sel;
            if (rd_done)                        grant_cnt <= grant_cnt + 32'd1;
            if (wd_release)                     timeout_err <= 1'b1;
            if (state != ST_GRANT || any_strobe || P_TIMEOUT == 0) wd_cnt <= '0;
            else                                                    wd_cnt <= wd_cnt + 32'd1;
        end
    end

    // Muxes key off the registered sel; strobes reach only the granted channel, and only in GRANT.
    always_comb begin
        hdr_empty_sel = 1'b1;
        hdr_data_sel  = '0;
        wvb_data_sel  = '0;
        ch_hdr_rdreq  = '0;
        ch_wvb_rdreq  = '0;
        ch_wvb_rddone = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (sel == CHAN_W'(k)) begin
                hdr_empty_sel    = ch_hdr_empty[k];
                hdr_data_sel     = ch_hdr_data[k*P_HDR_WIDTH +: P_HDR_WIDTH];
                wvb_data_sel     = ch_wvb_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
                ch_hdr_rdreq[k]  = busy & rdr.rdr_hdr_rdreq;
                ch_wvb_rdreq[k]  = busy & rdr.rdr_wvb_rdreq;
                ch_wvb_rddone[k] = busy & rdr.rdr_rddone;
            end
        end
    end

    assign rdr.rdr_hdr_empty = busy ? hdr_empty_sel : 1'b1;
    assign rdr.rdr_hdr_data  = hdr_data_sel;
    assign rdr.rdr_wvb_data  = wvb_data_sel;
    assign rdr.rdr_chan      = sel;

endmodule

// File: tb/tb_wvb_rdout_arbiter.sv
// Directed bench for wvb_rdout_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_wvb_rdout_arbiter;
    import wvb_rdout_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int HW = 80;
    localparam int DW = 22;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [N-1:0]      chan_en;
    logic [N-1:0]      ch_hdr_empty;
    logic [N*HW-1:0]   ch_hdr_data;
    logic [N*DW-1:0]   ch_wvb_data;
    logic [N-1:0]      ch_hdr_rdreq;
    logic [N-1:0]      ch_wvb_rdreq;
    logic [N-1:0]      ch_wvb_rddone;
    logic              busy;
    logic              timeout_err;
    logic [31:0]       grant_cnt;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;

    wvb_rdout_arbiter_if #(.P_HDR_WIDTH(HW), .P_DATA_WIDTH(DW)) rdr_bus ();

    wvb_rdout_arbiter #(
        .N_CHAN       (N),
        .P_HDR_WIDTH  (HW),
        .P_DATA_WIDTH (DW),
        .P_TIMEOUT    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .chan_en       (chan_en),
        .ch_hdr_empty  (ch_hdr_empty),
        .ch_hdr_data   (ch_hdr_data),
        .ch_wvb_data   (ch_wvb_data),
        .ch_hdr_rdreq  (ch_hdr_rdreq),
        .ch_wvb_rdreq  (ch_wvb_rdreq),
        .ch_wvb_rddone (ch_wvb_rddone),
        .rdr           (rdr_bus),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .grant_cnt     (grant_cnt),
        .dbg_state     (dbg_state)
    );

    // clock / time limit
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [3:0]  empty;
        logic        h, w, d;
        logic        e_busy, e_hempty;
        logic [3:0]  e_chan, e_hrd, e_wrd, e_done;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [HW-1:0] hdr_pat(input int k);
        return {16'hC0DE, 32'(k), 32'h1234_0000 + 32'(k)};
    endfunction

    function automatic logic [DW-1:0] wvb_pat(input int k);
        return 22'h15000 + 22'(k);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic clr_strobes();
        rdr_bus.rdr_hdr_rdreq = 1'b0;
        rdr_bus.rdr_wvb_rdreq = 1'b0;
        rdr_bus.rdr_rddone    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr_strobes();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int gap, output bit ok);
        gap = 0;
        ok  = 1'b1;
        @(negedge clk);
        clr_strobes();
        #1;
        while (!(busy === 1'b1 && rdr_bus.rdr_hdr_empty === 1'b0)) begin
            gap++;
            if (gap > 40) begin
                checks++;
                errors++;
                $display("FAIL grant_wait: got no grant expected grant within 40 cycles");
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    // Full readout on exp_ch: header pop, n_wvb data pops, rddone (left asserted on return).
    task automatic readout(input int exp_ch, input int n_wvb, input bit drop_en, output int gap);
        logic [3:0] oh;
        bit ok;
        oh = 4'(1 << exp_ch);
        wait_grant(gap, ok);
        if (!ok) return;
        chk("rdr_chan", 80'(rdr_bus.rdr_chan), 80'(exp_ch));
        chk("hdr_data", 80'(rdr_bus.rdr_hdr_data), 80'(hdr_pat(exp_ch)));
        chk("wvb_data", 80'(rdr_bus.rdr_wvb_data), 80'(wvb_pat(exp_ch)));
        rdr_bus.rdr_hdr_rdreq = 1'b1;
        #1;
        chk("hdr_rdreq_route", 80'(ch_hdr_rdreq), 80'(oh));
        @(negedge clk);
        rdr_bus.rdr_hdr_rdreq = 1'b0;
        if (drop_en) en = 1'b0;
        for (int i = 0; i < n_wvb; i++) begin
            rdr_bus.rdr_wvb_rdreq = 1'b1;
            #1;
            chk("wvb_rdreq_route", 80'(ch_wvb_rdreq), 80'(oh));
            chk("busy_in_readout", 80'(busy), 80'(1));
            @(negedge clk);
        end
        rdr_bus.rdr_wvb_rdreq = 1'b0;
        rdr_bus.rdr_rddone    = 1'b1;
        #1;
        chk("rddone_route", 80'(ch_wvb_rddone), 80'(oh));
        chk("busy_at_rddone", 80'(busy), 80'(1));
    endtask

    initial begin
        int gap;
        int n;
        bit ok;

        vecs[0]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'h0, 4'h0, 4'h0, 32'd0};
        vecs[1]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'h4, 4'h0, 4'h0, 32'd0};
        vecs[2]  = '{4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 4'h4, 4'h0, 32'd0};
        vecs[3]  = '{4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 4'h4, 4'h0, 32'd0};
        vecs[4]  = '{4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 4'h4, 4'h0, 32'd0};
        vecs[5]  = '{4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 4'h4, 4'h0, 32'd0};
        vecs[6]  = '{4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 4'h4, 4'h0, 32'd0};
        vecs[7]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'h0, 4'h0, 4'h4, 32'd0};
        vecs[8]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'h0, 4'h0, 4'h0, 32'd1};
        vecs[9]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'h0, 4'h0, 4'h0, 32'd1};
        vecs[10] = '{4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'h0, 4'h0, 4'h0, 32'd1};
        vecs[11] = '{4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 4'h0, 4'h0, 32'd1};
        vecs[12] = '{4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'h0, 4'h0, 4'h4, 32'd1};
        vecs[13] = '{4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'h0, 4'h0, 4'h0, 32'd2};

        for (int k = 0; k < N; k++) begin
            ch_hdr_data[k*HW +: HW] = hdr_pat(k);
            ch_wvb_data[k*DW +: DW] = wvb_pat(k);
        end
        rst_n        = 1'b0;
        en           = 1'b1;
        chan_en      = 4'hF;
        ch_hdr_empty = 4'hF;
        clr_strobes();

        // reset state
        do_reset();
        #1;
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_hdr_empty", 80'(rdr_bus.rdr_hdr_empty), 80'(1));
        chk("rst_chan", 80'(rdr_bus.rdr_chan), 80'(0));
        chk("rst_strobes", 80'({ch_hdr_rdreq, ch_wvb_rdreq, ch_wvb_rddone}), 80'(0));
        chk("rst_timeout_err", 80'(timeout_err), 80'(0));
        chk("rst_grant_cnt", 80'(grant_cnt), 80'(0));
        chk("rst_state", 80'(dbg_state), 80'(ST_IDLE));

        // single requester ch2, per-cycle table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ch_hdr_empty          = vecs[i].empty;
            rdr_bus.rdr_hdr_rdreq = vecs[i].h;
            rdr_bus.rdr_wvb_rdreq = vecs[i].w;
            rdr_bus.rdr_rddone    = vecs[i].d;
            #1;
            chk($sformatf("v%0d_busy", i), 80'(busy), 80'(vecs[i].e_busy));
            chk($sformatf("v%0d_hdr_empty", i), 80'(rdr_bus.rdr_hdr_empty), 80'(vecs[i].e_hempty));
            chk($sformatf("v%0d_chan", i), 80'(rdr_bus.rdr_chan), 80'(vecs[i].e_chan));
            chk($sformatf("v%0d_hdr_rdreq", i), 80'(ch_hdr_rdreq), 80'(vecs[i].e_hrd));
            chk($sformatf("v%0d_wvb_rdreq", i), 80'(ch_wvb_rdreq), 80'(vecs[i].e_wrd));
            chk($sformatf("v%0d_rddone", i), 80'(ch_wvb_rddone), 80'(vecs[i].e_done));
            chk($sformatf("v%0d_grant_cnt", i), 80'(grant_cnt), 80'(vecs[i].e_cnt));
            if (vecs[i].e_busy)
                chk($sformatf("v%0d_hdr_data", i), 80'(rdr_bus.rdr_hdr_data), 80'(hdr_pat(2)));
        end

        // all channels requesting: strict rotation with a two-cycle gap
        do_reset();
        ch_hdr_empty = 4'h0;
        chan_en      = 4'hF;
        for (int i = 0; i < 8; i++) begin
            readout(i % 4, 2, 1'b0, gap);
            if (i > 0) chk("rotation_gap", 80'(gap), 80'(2));
        end
        @(negedge clk);
        clr_strobes();
        #1;
        chk("rotation_grant_cnt", 80'(grant_cnt), 80'(8));

        // masked channels 0 and 2
        do_reset();
        chan_en = 4'b1010;
        for (int i = 0; i < 6; i++) readout((i % 2 == 0) ? 1 : 3, 1, 1'b0, gap);

        // en dropped mid-readout on ch1
        do_reset();
        chan_en      = 4'hF;
        ch_hdr_empty = 4'b1101;
        readout(1, 3, 1'b1, gap);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clr_strobes();
            #1;
            chk("en_low_no_grant", 80'(busy), 80'(0));
        end
        en = 1'b1;
        readout(1, 1, 1'b0, gap);

        // watchdog: stall after the header pop
        do_reset();
        ch_hdr_empty = 4'h0;
        wait_grant(gap, ok);
        chk("wd_first_chan", 80'(rdr_bus.rdr_chan), 80'(0));
        chk("wd_err_before", 80'(timeout_err), 80'(0));
        rdr_bus.rdr_hdr_rdreq = 1'b1;
        @(negedge clk);
        rdr_bus.rdr_hdr_rdreq = 1'b0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("wd_idle_cycles", 80'(n), 80'(16));
        chk("wd_hdr_empty", 80'(rdr_bus.rdr_hdr_empty), 80'(1));
        chk("wd_timeout_err", 80'(timeout_err), 80'(1));
        chk("wd_grant_cnt", 80'(grant_cnt), 80'(0));
        readout(1, 1, 1'b0, gap);
        @(negedge clk);
        clr_strobes();
        #1;
        chk("wd_after_grant_cnt", 80'(grant_cnt), 80'(1));
        chk("wd_err_sticky", 80'(timeout_err), 80'(1));

        // reset while ch3 is granted
        chan_en = 4'b1000;
        wait_grant(gap, ok);
        chk("rg_chan", 80'(rdr_bus.rdr_chan), 80'(3));
        rdr_bus.rdr_wvb_rdreq = 1'b1;
        #1;
        chk("rg_route", 80'(ch_wvb_rdreq), 80'(4'b1000));
        @(negedge clk);
        rst_n   = 1'b0;
        chan_en = 4'hF;
        @(negedge clk);
        #1;
        chk("rg_busy", 80'(busy), 80'(0));
        chk("rg_hdr_empty", 80'(rdr_bus.rdr_hdr_empty), 80'(1));
        chk("rg_strobes", 80'({ch_hdr_rdreq, ch_wvb_rdreq, ch_wvb_rddone}), 80'(0));
        chk("rg_timeout_err", 80'(timeout_err), 80'(0));
        chk("rg_grant_cnt", 80'(grant_cnt), 80'(0));
        chk("rg_state", 80'(dbg_state), 80'(ST_IDLE));
        rst_n = 1'b1;
        clr_strobes();
        readout(0, 1, 1'b0, gap);
        @(negedge clk);
        clr_strobes();

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wvb_rdout_arbiter.md
Name: wvb_rdout_arbiter

Overview:
Shares one wvb_reader between N_CHAN waveform_acquisition channels. Round-robin arbitration over channels with a pending header (hdr_empty low), masked by chan_en. The granted channel's header and waveform data are muxed to the reader, and the reader's rdreq/rddone strobes are routed back to that channel only. Sits between the per-channel waveform buffers and WVB_READER; xdom drives the enable, mask and timeout configuration and reads the status.

Parameters:
N_CHAN, 4, number of acquisition channels (2..16)
P_HDR_WIDTH, 80, header word width
P_DATA_WIDTH, 22, waveform data word width
P_TIMEOUT, 65535, idle cycles in GRANT before forced release; 0 disables the watchdog

Ports:
clk  in  1  logic clock (lclk, 125 MHz)
rst_n  in  1  synchronous active-low reset
en  in  1  arbitration enable (xdom)
chan_en  in  N_CHAN  per-channel participation mask
ch_hdr_empty  in  N_CHAN  per-channel header FIFO empty
ch_hdr_data  in  N_CHAN*P_HDR_WIDTH  per-channel header, channel k at [k*W +: W]
ch_wvb_data  in  N_CHAN*P_DATA_WIDTH  per-channel waveform data
ch_hdr_rdreq  out  N_CHAN  header pop strobe to each channel
ch_wvb_rdreq  out  N_CHAN  data pop strobe to each channel
ch_wvb_rddone  out  N_CHAN  readout-complete strobe to each channel
rdr_hdr_empty  out  1  to reader; low only when a channel is granted and that channel is non-empty
rdr_hdr_data  out  P_HDR_WIDTH  muxed header
rdr_wvb_data  out  P_DATA_WIDTH  muxed data
rdr_chan  out  4  granted channel index
rdr_hdr_rdreq  in  1  from reader
rdr_wvb_rdreq  in  1  from reader
rdr_rddone  in  1  from reader
busy  out  1  high in GRANT
timeout_err  out  1  sticky; set on watchdog release, cleared only by reset
grant_cnt  out  32  number of completed grants, wraps at 2^32

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; last_ptr=N_CHAN-1, so channel 0 has first priority.
- Output reset values: all ch_* strobes 0, rdr_hdr_empty=1, rdr_chan=0, busy=0, timeout_err=0, grant_cnt=0. Reset mid-GRANT drops the grant immediately and issues no rddone.
- req = ~ch_hdr_empty & chan_en, gated by en.
- States:
  - IDLE: if req≠0, choose the first set bit searching last_ptr+1, last_ptr+2, … modulo N_CHAN. Register sel, go to GRANT. Selection is registered, so a request seen at edge t is presented to the reader from cycle t+1.
  - GRANT:
    - rdr_chan=sel; rdr_hdr_empty=ch_hdr_empty[sel]; data muxes are combinational from the registered sel.
    - ch_hdr_rdreq[sel]=rdr_hdr_rdreq, ch_wvb_rdreq[sel]=rdr_wvb_rdreq, ch_wvb_rddone[sel]=rdr_rddone; all other channels see 0 (same-cycle pass-through, zero latency).
    - On rdr_rddone: last_ptr<=sel, grant_cnt++, go to RELEASE.
  - RELEASE: one cycle with rdr_hdr_empty=1, so the reader cannot re-pop before re-arbitration. Then go to IDLE.
- Once granted, a readout always completes. Deasserting en, or clearing chan_en[sel], during GRANT does not abort; the change takes effect at the next IDLE.
- Watchdog: counter cleared on entering GRANT and on any rdr_hdr_rdreq, rdr_wvb_rdreq or rdr_rddone; increments otherwise. When it reaches P_TIMEOUT (non-zero): set timeout_err, last_ptr<=sel, go to RELEASE with no rddone issued and grant_cnt unchanged.
- Strobes from the reader in IDLE/RELEASE are dropped (not routed to any channel).
- With a single requester, back-to-back grants are separated by exactly 2 idle cycles (RELEASE, IDLE).

Decomposition:
- Shared include: state encodings (IDLE/GRANT/RELEASE) and the channel-index width constant (clog2 of N_CHAN, fixed at 4 bits).
- Sub-module rr_arbiter (combinational round-robin priority pick: req vector + last_ptr -> valid + index); reusable elsewhere in the design.
- Top: FSM, muxes, watchdog, counters.

Test Plan:
1. Only ch2 non-empty, en=1, chan_en=4'hF -> rdr_chan=2 and rdr_hdr_empty=0 one cycle after request; reader hdr_rdreq, 5 wvb_rdreq, rddone appear only on ch2 strobes; grant_cnt=1.
2. All 4 channels continuously non-empty, 8 readouts -> grant order 0,1,2,3,0,1,2,3; 2-cycle gap between rddone and next rdr_hdr_empty=0.
3. chan_en=4'b1010, all non-empty -> grants alternate 1,3 only; ch0/ch2 strobes stay 0.
4. Drop en mid-GRANT on ch1 -> readout continues, rddone routed to ch1, then no new grant until en=1.
5. P_TIMEOUT=16, reader stalls after hdr_rdreq -> release 16 idle cycles later, timeout_err=1, grant_cnt unchanged, next grant goes to the following channel.
6. rst_n=0 while ch3 granted -> next cycle busy=0, rdr_hdr_empty=1, all strobes 0, timeout_err=0, grant_cnt=0; after release, ch0 wins when all are requesting.
